// File: rtl/bcd_display_scan_pkg.sv
// rtl/bcd_display_scan_pkg.sv - shared glyphs, digit geometry and slot index type for the display scanner.
package bcd_display_scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;

    typedef logic [1:0] digit_idx_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_display_scan_bcd_to_seg.sv
// rtl/bcd_display_scan_bcd_to_seg.sv - combinational BCD to active-low seven-segment decoder.
module bcd_to_seg
    import bcd_display_scan_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_code,
    output logic [6:0]         o_seg
);

    // Non-BCD codes show a dash so an upstream counter fault is never hidden as a blank.
    always_comb begin
        o_seg = SEG_DASH;
        case (i_code)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// rtl/bcd_display_scan.sv - four-digit multiplexed seven-segment scanner with per-frame snapshot and guard band.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits 3..1.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        c,
    input  logic        r,
    input  logic [15:0] d,
    input  logic [3:0]  dp,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dpo,
    output logic        frame
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    digit_idx_t       r_idx;
    logic [15:0]      r_shadow_d;
    logic [3:0]       r_shadow_dp;

    logic             w_term;
    logic             w_snap;
    logic             w_blank;
    logic             w_suppress;
    logic [31:0]      w_cnt_ext;
    logic [3:0]       w_digit;
    logic             w_dp;
    logic [6:0]       w_seg;

    assign w_term    = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_snap    = w_term && (r_idx == digit_idx_t'(NUM_DIGITS - 1));
    assign frame     = w_snap && !r;
    assign w_cnt_ext = 32'(r_cnt);
    assign w_blank   = (w_cnt_ext < 32'(BLANK_CYCLES));
    assign w_digit   = r_shadow_d[r_idx*DIGIT_W +: DIGIT_W];
    assign w_dp      = r_shadow_dp[r_idx];

    bcd_to_seg u_dec (
        .i_code (w_digit),
        .o_seg  (w_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // w_lead_nz[i]: some shadow digit at position i or above is non-zero
    logic [3:0] w_lead_nz;
    always_comb begin
        w_lead_nz    = 4'b0001;
        w_lead_nz[3] = (r_shadow_d[15:12] != 4'd0);
        w_lead_nz[2] = w_lead_nz[3] || (r_shadow_d[11:8] != 4'd0);
        w_lead_nz[1] = w_lead_nz[2] || (r_shadow_d[7:4]  != 4'd0);
        w_suppress   = !w_lead_nz[r_idx];
    end
`else
    assign w_suppress = 1'b0;
`endif

    always_ff @(posedge c) begin
        if (r) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shadow_d  <= '0;
            r_shadow_dp <= '0;
        end else if (w_term) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
            if (w_snap) begin
                r_shadow_d  <= d;
                r_shadow_dp <= dp;
            end
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Outputs are registered from the current slot state, so they trail it by one cycle.
    always_ff @(posedge c) begin
        if (r || w_blank || w_suppress) begin
            an  <= 4'b1111;
            seg <= SEG_OFF;
            dpo <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << r_idx);
            seg <= w_seg;
            dpo <= ~w_dp;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb/tb_bcd_display_scan.sv - randomized self-checking bench with a time-based display model.
module tb_bcd_display_scan;

    localparam int RD    = 8;
    localparam int BL    = 2;
    localparam int FRAME = 4 * RD;

    logic        c = 1'b0;
    logic        r = 1'b1;
    logic [15:0] d = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dpo;
    logic        frame;

    int n_tests = 0;
    int n_fail  = 0;

    int          t = 0;
    logic        mv = 1'b0;
    logic [15:0] m_d = '0;
    logic [3:0]  m_p = '0;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dpo = 1'b1;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    bcd_display_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
        .c     (c),
        .r     (r),
        .d     (d),
        .dp    (dp),
        .an    (an),
        .seg   (seg),
        .dpo   (dpo),
        .frame (frame)
    );

    always #5 c = ~c;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Display content for the cycle after time step tt, from the slot/phase arithmetic.
    function automatic logic [11:0] model_out(input int tt, input logic [15:0] sd, input logic [3:0] sp);
        int         slot;
        int         ph;
        logic [3:0] dig;
        logic       sup;
        slot = (tt / RD) % 4;
        ph   = tt % RD;
        dig  = sd[slot*4 +: 4];
        sup  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0) begin
            sup = 1'b1;
            for (int j = slot; j < 4; j++)
                if (sd[j*4 +: 4] != 4'd0) sup = 1'b0;
        end
`endif
        if (ph < BL || sup) return {4'hF, 7'h7F, 1'b1};
        return {~(4'b0001 << slot), glyph[dig], ~sp[slot]};
    endfunction

    always @(posedge c) begin
        if (r) begin
            t     <= 0;
            m_d   <= '0;
            m_p   <= '0;
            e_an  <= 4'hF;
            e_seg <= 7'h7F;
            e_dpo <= 1'b1;
            mv    <= 1'b1;
        end else begin
            {e_an, e_seg, e_dpo} <= model_out(t, m_d, m_p);
            if (t % FRAME == FRAME - 1) begin
                m_d <= d;
                m_p <= dp;
            end
            t <= t + 1;
        end
    end

    always @(negedge c) begin
        if (mv) begin
            chk("an", 32'(an), 32'(e_an));
            chk("seg", 32'(seg), 32'(e_seg));
            chk("dpo", 32'(dpo), 32'(e_dpo));
            chk("frame", 32'(frame), 32'(!r && (t % FRAME == FRAME - 1)));
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge c);
        #2;
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        while (n < 200) begin
            @(negedge c);
            n++;
            if (frame === 1'b1) return;
        end
        chk("frame_timeout", 32'(n), 32'd0);
    endtask

    task automatic at_negedges(input int k);
        repeat (k) @(negedge c);
    endtask

    int n;

    initial begin
        r  = 1'b1;
        d  = 16'h1234;
        dp = 4'h0;
        tick(1);
        @(negedge c);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dpo", 32'(dpo), 32'd1);
        chk("rst_frame", 32'(frame), 32'd0);
        tick(1);
        r = 1'b0;

        // first snapshot lands at cycle 31 after release
        wait_frame(n);
        chk("first_frame_cycle", 32'(n), 32'd32);
        at_negedges(4);
        chk("slot0_an", 32'(an), 32'b1110);
        chk("slot0_seg", 32'(seg), 32'b0011001);
        at_negedges(24);
        chk("slot3_an", 32'(an), 32'b0111);
        chk("slot3_seg", 32'(seg), 32'b1111001);

        // tearing: change lands mid-frame, held until next snapshot
        d = 16'h0959;
        wait_frame(n);
        tick(1);
        d = 16'h1000;
        at_negedges(20);
        chk("tear_slot2_an", 32'(an), 32'b1011);
        chk("tear_slot2_seg", 32'(seg), 32'b0010000);
        wait_frame(n);
        at_negedges(28);
        chk("new_slot3_an", 32'(an), 32'b0111);
        chk("new_slot3_seg", 32'(seg), 32'b1111001);

        // invalid code and decimal point
        d  = 16'h00A0;
        dp = 4'b0100;
        wait_frame(n);
        at_negedges(12);
        chk("inv_slot1_an", 32'(an), 32'b1101);
        chk("inv_slot1_seg", 32'(seg), 32'b0111111);
        chk("inv_slot1_dpo", 32'(dpo), 32'd1);
        at_negedges(8);
`ifdef LEADING_ZERO_BLANK_EN
        chk("inv_slot2_an", 32'(an), 32'b1111);
        chk("inv_slot2_dpo", 32'(dpo), 32'd1);
`else
        chk("inv_slot2_an", 32'(an), 32'b1011);
        chk("inv_slot2_seg", 32'(seg), 32'b1000000);
        chk("inv_slot2_dpo", 32'(dpo), 32'd0);
`endif

        // reset in the middle of slot 2
        wait_frame(n);
        at_negedges(17);
        tick(1);
        r = 1'b1;
        tick(1);
        r = 1'b0;
        @(negedge c);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_seg", 32'(seg), 32'h7F);
        wait_frame(n);
        chk("midrst_frame_cycle", 32'(n), 32'd31);

        // random digits and dp changing at random points in the frame
        for (int k = 0; k < 250; k++) begin
            d  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d[15:8] = 8'h00;
            dp = 4'($urandom);
            tick($urandom_range(1, 40));
        end
        tick(2 * FRAME);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Downstream consumer of the four cascaded BCD counter stages (ones/tens of seconds and minutes) in the stopwatch datapath.
- Takes four 4-bit BCD digits and time-multiplexes them onto one common-anode 4-digit seven-segment display.
- Snapshots the digits once per frame so a display frame never mixes pre-carry and post-carry digit values.
- Inserts a short anode-off guard at the start of each digit slot to suppress ghosting.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot; legal range ≥ 4.
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ BLANK_CYCLES < REFRESH_DIV.

Ports:
- c  input  1  system clock; all state updates on the rising edge.
- r  input  1  reset, synchronous, active-high.
- d  input  16  BCD digits: d[3:0] is digit 0 (rightmost) … d[15:12] is digit 3.
- dp  input  4  decimal-point request per digit, same index order as d.
- an  output  4  anode enables, active-low; an[i] drives digit i.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dpo  output  1  decimal-point segment, active-low.
- frame  output  1  one-cycle pulse, high on the cycle the snapshot loads.

Behaviour:
- Reset (synchronous, active-high) sets:
  - prescaler cnt = 0, slot index idx = 0
  - shadow digits = 0, shadow dp = 0
  - an = 4'b1111, seg = 7'b1111111, dpo = 1, frame = 0
  - Reset mid-frame aborts the frame; scanning restarts at slot 0 on the first cycle after release.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1.
  - At terminal count, cnt wraps to 0 and idx advances 0→1→2→3→0.
- Snapshot:
  - When cnt == REFRESH_DIV-1 and idx == 3, shadow ← {d, dp} and frame = 1 for that one cycle.
  - d and dp are not sampled at any other time. Changes on d mid-frame are invisible until the next frame.
- Output register (outputs lag the internal (idx, cnt) state by exactly one cycle):
  - If cnt < BLANK_CYCLES: an = 4'b1111, seg = 7'b1111111, dpo = 1.
  - Otherwise:
    - an is all ones except an[idx] = 0.
    - seg = decode(shadow digit idx).
    - dpo = ~shadow dp[idx].
- Decode:
  - Codes 0–9 map to standard glyphs: 0 → 7'b1000000, 1 → 7'b1111001, 8 → 7'b0000000.
  - Codes 10–15 map to a dash (g segment only) → 7'b0111111.
  - Invalid codes must never produce a blank, so a fault in an upstream counter stage stays visible.
- Frame period = 4 × REFRESH_DIV cycles. The first snapshot occurs 4 × REFRESH_DIV − 1 cycles after reset release, so frame 0 displays 0000.
- No handshake: inputs are level-sampled and there is no backpressure.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN
  - Defined: digit i (i = 3,2,1) is suppressed when its shadow digit and every more-significant shadow digit equal 0.
    - Suppressed means an[i] = 1, seg = 7'b1111111, dpo = 1 for the whole slot.
    - Digit 0 is never suppressed.
    - An invalid code (10–15) counts as non-zero.
    - Suppression is evaluated on shadow values, never on live d.
  - Undefined: all four digits are always displayed, including leading zeros.

Decomposition:
- Shared package:
  - Segment glyph constants SEG_0..SEG_9 and SEG_DASH, SEG_OFF.
  - NUM_DIGITS = 4, DIGIT_W = 4.
  - Digit-index type (2-bit).
- Sub-module bcd_to_seg: purely combinational 4-bit → 7-bit active-low decoder using the package glyphs.
  - It is reusable by any other display path and is instantiated once, muxed by idx.
- Prescaler, slot index, shadow register and output register stay in the top module.

Test Plan (REFRESH_DIV = 8, BLANK_CYCLES = 2 unless noted):
- Reset release, d = 16'h1234 held:
  - Cycles 1–31 show only 0000.
  - frame pulses at cycle 31.
  - From cycle 32 onward, slot 0 shows seg = 7'b0011001 (4) with an = 4'b1110 during cnt 2..7.
  - Slot 3 shows 1 with an = 4'b0111.
- Guard band: on every slot, the first 2 output cycles show an = 4'b1111 and seg = 7'b1111111. With BLANK_CYCLES = 0, no all-off cycles occur.
- Tearing: change d from 16'h0959 to 16'h1000 at the cycle after a frame pulse. The display keeps showing 0959 for all 4 slots; the new value appears only after the next frame pulse.
- Invalid code: d = 16'h00A0, dp = 4'b0100:
  - Digit 1 shows 7'b0111111.
  - Digit 2 shows 0 with dpo = 0.
  - All other slots have dpo = 1.
- Mid-frame reset: assert r for 1 cycle during slot 2. On the next cycle an = 4'b1111, then scanning restarts at slot 0 with shadow = 0 and frame next at cycle 31.
- LEADING_ZERO_BLANK_EN defined, d = 16'h0005:
  - Digits 3, 2, 1 keep an = 1 for their whole slots; digit 0 shows 5.
  - With d = 16'h0000, only digit 0 lights (shows 0).
  - With d = 16'h0A00, digit 3 is suppressed and digits 2 (dash), 1 and 0 are displayed.
